// File: rtl/mash_pkg.sv
// Shared types and helpers for the MASH 1-1 modulator: DAC code type, reset code,
// and the carry-to-code mapping.
package mash_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef logic [1:0] dac_code_t;

  localparam dac_code_t DAC_CODE_ZERO = 2'd1;

  // y = c1 + c2 - c2_d lies in -1..+2, so code = y + 1 = c1 + c2 + (1 - c2_d).
  function automatic dac_code_t y_to_code(input logic c1, input logic c2, input logic c2_d);
    dac_code_t code;
    code = dac_code_t'({1'b0, c1}) + dac_code_t'({1'b0, c2}) + dac_code_t'({1'b0, ~c2_d});
    return code;
  endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// First-order accumulator stage: combinational sum/carry of acc + addend,
// registered back into acc on each modulator tick (wraps modulo 2^DATA_WIDTH).
module mash_acc_stage
  import mash_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry
);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH:0]   total;

  assign total = {1'b0, acc} + {1'b0, addend};
  assign sum   = total[DATA_WIDTH-1:0];
  assign carry = total[DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (tick) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/axis_mash11_mod.sv
// MASH 1-1 delta-sigma modulator fed by an AXI-stream NCO sample stream through a
// 1-deep buffer; emits a 2-bit offset-binary DAC code once per OSR_DIV-cycle tick.
module axis_mash11_mod
  import mash_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OSR_DIV    = 1,
  parameter int UCNT_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [1:0]            dac_code,
  output logic                  dac_valid,
  output logic [UCNT_WIDTH-1:0] underrun_cnt
);

  localparam int             CNT_W    = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR_DIV - 1);

  logic [DATA_WIDTH-1:0] sample_buf;
  logic [DATA_WIDTH-1:0] x_hold;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] s1;
  logic [DATA_WIDTH-1:0] s2_unused;
  logic                  buf_valid;
  logic                  accept;
  logic                  tick;
  logic                  c1;
  logic                  c2;
  logic                  c2_d;
  logic [CNT_W-1:0]      cnt;

  // tready comes straight from the buffer flag, never from tvalid.
  assign s_axis_data_tready = ~buf_valid;
  assign accept             = s_axis_data_tvalid & ~buf_valid;
  assign tick               = enable && (cnt == CNT_LAST);
  assign x                  = buf_valid ? sample_buf : x_hold;

  mash_acc_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage1 (
    .clk    (aclk),
    .rst_n  (arst_n),
    .tick   (tick),
    .addend (x),
    .sum    (s1),
    .carry  (c1)
  );

  // Stage 2 integrates the freshly computed s1 within the same tick.
  mash_acc_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage2 (
    .clk    (aclk),
    .rst_n  (arst_n),
    .tick   (tick),
    .addend (s1),
    .sum    (s2_unused),
    .carry  (c2)
  );

  // An underrun tick leaves tready high, so a sample may land on the same edge;
  // the load wins over the tick's clear and the sample waits for the next tick.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      sample_buf <= '0;
      buf_valid  <= 1'b0;
    end else if (accept) begin
      sample_buf <= s_axis_data_tdata;
      buf_valid  <= 1'b1;
    end else if (tick) begin
      buf_valid  <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      x_hold    <= '0;
      c2_d      <= 1'b0;
      dac_code  <= DAC_CODE_ZERO;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= tick;
      if (tick) begin
        x_hold   <= x;
        c2_d     <= c2;
        dac_code <= y_to_code(c1, c2, c2_d);
      end
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      underrun_cnt <= '0;
    end else if (tick && !buf_valid && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + UCNT_WIDTH'(1);
    end
  end

endmodule
